nios2_debug_mem_access_engine: RTL and testbench
================================================

Name: nios2_debug_mem_access_engine

Overview:
- System-clock stage directly downstream of the debug-slave sysclk synchroniser.
- Consumes the synchronised `jdo` payload and the `take_action_ocimem_a`, `take_action_ocimem_b` and `take_no_action_ocimem_a` strobes.
- Performs single-word Avalon-MM master reads and writes with auto-incrementing address.
- Returns `MonDReg`, `monitor_ready` and `monitor_error` to the JTAG side for host memory download and upload.

Parameters:
- `ADDR_W`, 16: word-address width; `avm_address` is `ADDR_W+2` bits.
- `TIMEOUT_CYCLES`, 255: max cycles a transfer may stall on `avm_waitrequest` (used only with `DBG_MEM_TIMEOUT_EN`).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `jdo` in 38: synchronised JTAG data payload.
- `take_action_ocimem_a` in 1: set-address command strobe (1 cycle).
- `take_action_ocimem_b` in 1: write-data command strobe (1 cycle).
- `take_no_action_ocimem_a` in 1: streaming-read command strobe (1 cycle).
- `avm_address` out `ADDR_W+2`: byte address `{word_addr, 2'b00}`.
- `avm_read` out 1: Avalon read request.
- `avm_write` out 1: Avalon write request.
- `avm_writedata` out 32: write data.
- `avm_byteenable` out 4: always `4'hF`.
- `avm_readdata` in 32: read data.
- `avm_waitrequest` in 1: slave stall.
- `MonDReg` out 32: last read data.
- `monitor_ready` out 1: last command completed.
- `monitor_error` out 1: sticky error (timeout or dropped command).
- `busy` out 1: transfer in progress.

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset values:
  - `word_addr`=0, `MonDReg`=0, `avm_writedata`=0.
  - `avm_read`=0, `avm_write`=0.
  - `monitor_ready`=1, `monitor_error`=0, `busy`=0.
  - State = IDLE.
- Reset mid-transfer: request drops the next cycle; no `MonDReg` update.
- Command decode, sampled only in IDLE:
  - `take_action_ocimem_a`: `word_addr <= jdo[ADDR_W+1:2]`. If `jdo[35]`=1, start a read at the new address (RD). Otherwise stay IDLE; `monitor_ready` stays 1.
  - `take_action_ocimem_b`: `avm_writedata <= jdo[34:3]`; go to WR.
  - `take_no_action_ocimem_a`: go to RD at the current `word_addr`.
- Simultaneous strobes: priority `ocimem_a` > `ocimem_b` > `no_action_a`; only one is accepted per cycle, the others are ignored without error.
- Strobe while not IDLE: dropped; `monitor_error` set.
- FSM states: IDLE, RD, WR.
- Entering RD or WR: `monitor_ready`<=0, `busy`<=1, and `avm_read` or `avm_write` asserted in the next cycle (1-cycle issue latency).
- Held-request rule: `avm_read`/`avm_write`, `avm_address` and `avm_writedata` are stable while `avm_waitrequest`=1.
- RD completion, on the cycle `avm_read`=1 and `avm_waitrequest`=0:
  - `MonDReg <= avm_readdata`.
  - Deassert `avm_read`; `word_addr` +1.
  - `monitor_ready`<=1, `busy`<=0; go to IDLE.
- WR completion, on the cycle `avm_write`=1 and `avm_waitrequest`=0:
  - Deassert `avm_write`; `word_addr` +1.
  - `monitor_ready`<=1; go to IDLE.
- Address increment wraps modulo 2^`ADDR_W` (all-ones wraps to 0).
- Zero-wait slave: a command finishes 2 cycles after its strobe; a new strobe is accepted in the cycle after `monitor_ready` rises.
- `monitor_error` clears only on `reset`, or on `take_action_ocimem_a` with `jdo[36]`=1; the clear also applies when that strobe starts a read.

Optional Feature:
- Macro: `DBG_MEM_TIMEOUT_EN`.
- With the macro defined:
  - A counter clears on request issue and increments each cycle `avm_waitrequest`=1.
  - When the count reaches `TIMEOUT_CYCLES` the request is deasserted, `monitor_error`<=1, `monitor_ready`<=1, and the FSM returns to IDLE.
  - `MonDReg` and `word_addr` stay unchanged.
- Without the macro: no counter is built and the engine waits indefinitely on `avm_waitrequest`.

Test Plan:
- Reset, then `ocimem_a` with `jdo[ADDR_W+1:2]`=0x0010 and `jdo[35]`=1, slave returns 0xCAFEF00D with zero wait:
  - `avm_address`=0x0040 with `avm_read` for 1 cycle.
  - `MonDReg`=0xCAFEF00D, `monitor_ready`=1, `word_addr`=0x0011.
- Three `ocimem_b` writes with data 1, 2, 3 after setting address 0x0020, 3 wait states each:
  - Writes land at 0x80, 0x84, 0x88.
  - `avm_write` stable through every stall.
- Address 0xFFFF then `no_action_a`: read issued at 0x3FFFC; `word_addr` wraps to 0x0000.
- `ocimem_b` and `no_action_a` in the same cycle: only WR executes; `monitor_error` stays 0.
- Strobe during a stalled RD: dropped; `monitor_error`=1. Then `ocimem_a` with `jdo[36]`=1 clears it.
- With `DBG_MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, `avm_waitrequest` held at 1:
  - `avm_read` drops after 8 stall cycles.
  - `monitor_error`=1, `monitor_ready`=1, `MonDReg` unchanged.
- Without the macro: the same stimulus leaves `avm_read` held.

Source files
------------

// File: rtl/nios2_debug_mem_access_engine.sv
// nios2_debug_mem_access_engine
// System-clock side of the debug memory path. Decodes the synchronised JTAG
// commands (set address / write data / streaming read) and performs
// single-word Avalon-MM transfers with an auto-incrementing word address.
// Optional build macro: DBG_MEM_TIMEOUT_EN adds a stall watchdog that aborts
// a transfer held by avm_waitrequest for TIMEOUT_CYCLES cycles.
module nios2_debug_mem_access_engine #(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W+1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_word_addr;
    logic [31:0]       r_mon_dreg;
    logic [31:0]       r_writedata;
    logic              r_read;
    logic              r_write;
    logic              r_ready;
    logic              r_error;
    logic              r_busy;

    logic              w_any_strobe;
    logic              w_req;
    logic              w_unused;

    assign w_any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign w_req        = r_read | r_write;

    // jdo carries bits this stage has no use for (command opcode remnants)
    assign w_unused = &{1'b0, jdo[37], jdo[1:0]};

`ifdef DBG_MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] r_stall_cnt;
`else
    // Watchdog is not built; the limit is only referenced to keep it declared
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    // Command decode, request issue/hold and completion handling
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_word_addr <= '0;
            r_mon_dreg  <= '0;
            r_writedata <= '0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_ready     <= 1'b1;
            r_error     <= 1'b0;
            r_busy      <= 1'b0;
`ifdef DBG_MEM_TIMEOUT_EN
            r_stall_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (take_action_ocimem_a) begin
                        r_word_addr <= jdo[ADDR_W+1:2];
                        if (jdo[36]) begin
                            r_error <= 1'b0;
                        end
                        if (jdo[35]) begin
                            r_state <= S_RD;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end else if (take_action_ocimem_b) begin
                        r_writedata <= jdo[34:3];
                        r_state     <= S_WR;
                        r_ready     <= 1'b0;
                        r_busy      <= 1'b1;
                    end else if (take_no_action_ocimem_a) begin
                        r_state <= S_RD;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end

                S_RD, S_WR: begin
                    // Commands cannot be queued behind a live transfer
                    if (w_any_strobe) begin
                        r_error <= 1'b1;
                    end
                    if (!w_req) begin
                        // First cycle in the state: raise the request
                        r_read  <= (r_state == S_RD);
                        r_write <= (r_state == S_WR);
`ifdef DBG_MEM_TIMEOUT_EN
                        r_stall_cnt <= '0;
`endif
                    end else if (!avm_waitrequest) begin
                        if (r_state == S_RD) begin
                            r_mon_dreg <= avm_readdata;
                        end
                        r_read      <= 1'b0;
                        r_write     <= 1'b0;
                        r_word_addr <= r_word_addr + 1'b1;
                        r_ready     <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
`ifdef DBG_MEM_TIMEOUT_EN
                    else if (r_stall_cnt == CNT_LAST) begin
                        // Abort: address and read data are left untouched
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        r_error <= 1'b1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_stall_cnt <= r_stall_cnt + 1'b1;
                    end
`endif
                end

                default: begin
                    r_state <= S_IDLE;
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign avm_address    = {r_word_addr, 2'b00};
    assign avm_read       = r_read;
    assign avm_write      = r_write;
    assign avm_writedata  = r_writedata;
    assign avm_byteenable = 4'hF;
    assign MonDReg        = r_mon_dreg;
    assign monitor_ready  = r_ready;
    assign monitor_error  = r_error;
    assign busy           = r_busy;

endmodule

// File: tb/tb_nios2_debug_mem_access_engine.sv
// Directed bench for nios2_debug_mem_access_engine. Inputs change 1 ns after
// the rising edge and outputs are sampled at that same point.
module tb_nios2_debug_mem_access_engine;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [37:0]       jdo = '0;
    logic              take_action_ocimem_a = 1'b0;
    logic              take_action_ocimem_b = 1'b0;
    logic              take_no_action_ocimem_a = 1'b0;
    logic [ADDR_W+1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [3:0]        avm_byteenable;
    logic [31:0]       avm_readdata = '0;
    logic              avm_waitrequest = 1'b0;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    nios2_debug_mem_access_engine #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .avm_address             (avm_address),
        .avm_read                (avm_read),
        .avm_write               (avm_write),
        .avm_writedata           (avm_writedata),
        .avm_byteenable          (avm_byteenable),
        .avm_readdata            (avm_readdata),
        .avm_waitrequest         (avm_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .busy                    (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_a(input logic [ADDR_W-1:0] addr, input logic rd, input logic clr);
        logic [37:0] j;
        j = '0;
        j[ADDR_W+1:2] = addr;
        j[35] = rd;
        j[36] = clr;
        jdo = j;
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic strobe_b(input logic [31:0] data);
        logic [37:0] j;
        j = '0;
        j[34:3] = data;
        jdo = j;
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic strobe_na();
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check_eq("rst_ready", monitor_ready, 1);
        check_eq("rst_error", monitor_error, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_read", avm_read, 0);
        check_eq("rst_write", avm_write, 0);
        check_eq("rst_mondreg", MonDReg, 0);
        check_eq("rst_addr", avm_address, 0);
        check_eq("rst_wdata", avm_writedata, 0);
        check_eq("byteenable", avm_byteenable, 4'hF);
        reset = 1'b0;
        tick();

        // Set address 0x0010 and read, zero-wait slave
        avm_readdata = 32'hCAFEF00D;
        strobe_a(16'h0010, 1'b1, 1'b0);
        check_eq("rd1_ready_low", monitor_ready, 0);
        check_eq("rd1_busy", busy, 1);
        check_eq("rd1_no_read_yet", avm_read, 0);
        tick();
        check_eq("rd1_read", avm_read, 1);
        check_eq("rd1_addr", avm_address, 18'h00040);
        tick();
        check_eq("rd1_read_drop", avm_read, 0);
        check_eq("rd1_mondreg", MonDReg, 32'hCAFEF00D);
        check_eq("rd1_ready", monitor_ready, 1);
        check_eq("rd1_busy_clr", busy, 0);
        check_eq("rd1_word_addr", dut.r_word_addr, 16'h0011);

        // Address 0x0020 without read, then three writes with 3 wait states
        strobe_a(16'h0020, 1'b0, 1'b0);
        check_eq("seta_ready", monitor_ready, 1);
        check_eq("seta_busy", busy, 0);
        check_eq("seta_no_read", avm_read, 0);
        for (int i = 0; i < 3; i++) begin
            avm_waitrequest = 1'b1;
            strobe_b(32'(i + 1));
            tick();
            check_eq($sformatf("wr%0d_write", i), avm_write, 1);
            check_eq($sformatf("wr%0d_addr", i), avm_address, 18'(32'h80 + 4 * i));
            check_eq($sformatf("wr%0d_data", i), avm_writedata, 32'(i + 1));
            for (int s = 0; s < 3; s++) begin
                tick();
                check_eq($sformatf("wr%0d_hold%0d_write", i, s), avm_write, 1);
                check_eq($sformatf("wr%0d_hold%0d_addr", i, s), avm_address, 18'(32'h80 + 4 * i));
            end
            avm_waitrequest = 1'b0;
            tick();
            check_eq($sformatf("wr%0d_done_write", i), avm_write, 0);
            check_eq($sformatf("wr%0d_done_ready", i), monitor_ready, 1);
        end
        check_eq("wr_word_addr", dut.r_word_addr, 16'h0023);
        check_eq("wr_mondreg_kept", MonDReg, 32'hCAFEF00D);

        // Address wrap: 0xFFFF then streaming read
        avm_readdata = 32'h12345678;
        strobe_a(16'hFFFF, 1'b0, 1'b0);
        strobe_na();
        tick();
        check_eq("wrap_read", avm_read, 1);
        check_eq("wrap_addr", avm_address, 18'h3FFFC);
        tick();
        check_eq("wrap_mondreg", MonDReg, 32'h12345678);
        check_eq("wrap_word_addr", dut.r_word_addr, 16'h0000);

        // Simultaneous ocimem_b and no_action_a: write wins, no error
        jdo = 38'(32'h0000A5A5) << 3;
        take_action_ocimem_b = 1'b1;
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        tick();
        check_eq("sim_write", avm_write, 1);
        check_eq("sim_read", avm_read, 0);
        check_eq("sim_wdata", avm_writedata, 32'h0000A5A5);
        tick();
        check_eq("sim_error", monitor_error, 0);
        check_eq("sim_ready", monitor_ready, 1);
        check_eq("sim_word_addr", dut.r_word_addr, 16'h0001);
        check_eq("sim_mondreg", MonDReg, 32'h12345678);

        // Strobe during a stalled read is dropped and flags an error
        avm_waitrequest = 1'b1;
        avm_readdata = 32'h0BADBEEF;
        strobe_na();
        tick();
        check_eq("drop_read", avm_read, 1);
        tick();
        strobe_b(32'hFFFF_FFFF);
        check_eq("drop_error", monitor_error, 1);
        check_eq("drop_no_write", avm_write, 0);
        check_eq("drop_read_held", avm_read, 1);
        check_eq("drop_addr_held", avm_address, 18'h00004);
        avm_waitrequest = 1'b0;
        tick();
        check_eq("drop_done_ready", monitor_ready, 1);
        check_eq("drop_mondreg", MonDReg, 32'h0BADBEEF);
        check_eq("drop_error_sticky", monitor_error, 1);
        strobe_a(16'h0005, 1'b0, 1'b1);
        check_eq("clr_error", monitor_error, 0);
        check_eq("clr_word_addr", dut.r_word_addr, 16'h0005);

        // Slave that never releases waitrequest
        avm_waitrequest = 1'b1;
        avm_readdata = 32'hDEADDEAD;
        strobe_na();
        tick();
        check_eq("to_read_issued", avm_read, 1);
`ifdef DBG_MEM_TIMEOUT_EN
        for (int s = 0; s < 7; s++) begin
            tick();
            check_eq($sformatf("to_stall%0d_read", s + 1), avm_read, 1);
        end
        tick();
        check_eq("to_read_drop", avm_read, 0);
        check_eq("to_error", monitor_error, 1);
        check_eq("to_ready", monitor_ready, 1);
        check_eq("to_mondreg", MonDReg, 32'h0BADBEEF);
        check_eq("to_word_addr", dut.r_word_addr, 16'h0005);
        avm_waitrequest = 1'b0;
`else
        for (int s = 0; s < 20; s++) begin
            tick();
        end
        check_eq("nto_read_held", avm_read, 1);
        check_eq("nto_ready_low", monitor_ready, 0);
        check_eq("nto_error", monitor_error, 0);
        avm_waitrequest = 1'b0;
        tick();
        check_eq("nto_done_mondreg", MonDReg, 32'hDEADDEAD);
        check_eq("nto_word_addr", dut.r_word_addr, 16'h0006);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
